// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART
// receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Zero-extended narrower words give the same XOR reduction.
  function automatic logic parity_f(
    input logic [7:0] data,
    input logic       odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period counter with a
// half-period preload for centring on the start bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic half,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0] MID  = W'(CLKS_PER_BIT / 2);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= half ? MID : '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a single-entry
// valid/ready output register and per-frame error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 parity_err_o,
  output logic                 overrun_o
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_q;
  logic rx_s;

  uart_rx_state_e state;
  uart_rx_state_e state_nx;

  logic tick;
  logic restart;
  logic half;
  logic sample;
  logic pchk;
  logic done;
  logic last_bit;

  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_q <= UART_IDLE_LEVEL;
      rx_s <= UART_IDLE_LEVEL;
    end else begin
      rx_q <= rx;
      rx_s <= rx_q;
    end
  end

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .half   (half),
    .tick   (tick)
  );

  assign last_bit = (bit_idx == LAST_BIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RX_IDLE: begin
        if (!rx_s) state_nx = RX_START;
      end
      RX_START: begin
        if (tick) state_nx = rx_s ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        if (tick && last_bit) begin
          state_nx = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (tick) state_nx = RX_STOP;
      end
      RX_STOP: begin
        if (tick) state_nx = rx_s ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        if (rx_s) state_nx = RX_IDLE;
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  // Timer realigns on every state entry; DATA bits reuse its wrap.
  always_comb begin
    restart = (state_nx != state);
    half    = (state_nx == RX_START);
    sample  = (state == RX_DATA) && tick;
    pchk    = (state == RX_PARITY) && tick;
    done    = (state == RX_STOP) && tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      perr    <= 1'b0;
    end else begin
      if ((state == RX_START) && tick) begin
        bit_idx <= '0;
        perr    <= 1'b0;
      end
      if (sample) begin
        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (pchk) begin
        perr <= parity_f(8'(shreg), PARITY_ODD != 0) ^ rx_s;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (done) begin
        if (!valid_o || ready_i) begin
          valid_o      <= 1'b1;
          data_o       <= shreg;
          frame_err_o  <= !rx_s;
          parity_err_o <= perr;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive front end: oversamples the asynchronous serial line `rx`, detects start bits, reassembles 8N1/8E1/8O1 frames LSB-first and presents each byte on a single-entry valid/ready output port. Sits directly downstream of the serial pin, between the line driven by the test stimulus and the byte-level logic of `uart`. Reports framing, parity and overrun errors per frame.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per bit period; must be an even value ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY_EN`, 1: 1 = one parity bit follows the data bits; 0 = no parity.
- `PARITY_ODD`, 0: 0 = even parity; 1 = odd parity. Ignored when `PARITY_EN` = 0.
- `clk`  input  1  sole clock; all state updates on posedge.
- `rst`  input  1  synchronous, active-high reset.
- `rx`  input  1  asynchronous serial line; idles high.
- `data_o`  output  DATA_BITS  received byte, LSB = first data bit on the line.
- `valid_o`  output  1  `data_o` and the error flags hold a complete frame.
- `ready_i`  input  1  consumer accepts the frame when `valid_o && ready_i`.
- `frame_err_o`  output  1  stop bit sampled low; qualified by `valid_o`.
- `parity_err_o`  output  1  parity mismatch; qualified by `valid_o`; always 0 when `PARITY_EN` = 0.
- `overrun_o`  output  1  one-cycle pulse: a frame completed while the output register was full, and that frame was dropped.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1. The FSM sees only `rx_s`, the synchronizer output.
- Bit timer: counts 0..CLKS_PER_BIT-1. Asserts `tick` at count CLKS_PER_BIT-1. Restarts from 0 on every state entry.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: when `rx_s` = 0, go to START and load the timer so that its first tick lands at count CLKS_PER_BIT/2-1, the bit centre.
  - START: at `tick`, if `rx_s` = 1 this is a false start; go to IDLE with no output. Otherwise go to DATA, bit index 0.
  - DATA: at each `tick`, shift `rx_s` into the MSB of the shift register (LSB-first reception). After DATA_BITS samples, go to PARITY, or to STOP if `PARITY_EN` = 0.
  - PARITY: at `tick`, `perr` = XOR of the data bits, XOR the parity bit, XOR `PARITY_ODD`. Go to STOP.
  - STOP: at `tick`, complete the frame. If `rx_s` = 1, go to IDLE. If `rx_s` = 0, set `frame_err` and go to BREAK.
  - BREAK: wait for `rx_s` = 1, then go to IDLE. This prevents a held-low line from producing back-to-back frames.
- Frame completion with the output register empty, or with `ready_i` = 1 in the same cycle: load `data_o`, `frame_err_o` and `parity_err_o`, and set `valid_o`.
- Frame completion while `valid_o && !ready_i`: keep the held frame unchanged, drop the new one, and pulse `overrun_o` for 1 cycle.
- `valid_o` clears on `valid_o && ready_i` unless a frame loads in the same cycle.
- Reset mid-frame: the FSM goes to IDLE and the partial frame is discarded. The next start bit is accepted only after `rx_s` has been seen high.

## Timing
- Reset values: `valid_o` = 0, `data_o` = 0, `frame_err_o` = 0, `parity_err_o` = 0, `overrun_o` = 0, FSM in IDLE, synchronizer outputs = 1.
- Start detect lags the `rx` falling edge by 2 cycles (synchronizer) + 1 cycle (FSM).
- Each sample is taken CLKS_PER_BIT/2 ± 1 cycles after the ideal bit edge.
- `valid_o` rises 1 cycle after the stop-bit sample tick.
- Total latency, `rx` falling edge to `valid_o`: 3 + CLKS_PER_BIT/2 + (DATA_BITS + PARITY_EN + 1)·CLKS_PER_BIT cycles.
  - With defaults: 3 + 8 + 160 = 171 cycles.
- Output register holds one frame; the handshake has no combinational path from `ready_i` to `valid_o`.
- Tolerates ±4 % baud mismatch at defaults.

## Structure
- `uart_pkg` holds:
  - `uart_rx_state_e`, the FSM enum;
  - the `UART_IDLE_LEVEL` = 1'b1 constant;
  - a `parity_f(data, odd)` function, shared with the future `uart_tx`.
- Sub-module `uart_bit_timer`: parameter CLKS_PER_BIT; inputs `clk`, `rst`, `restart`, `half`; output `tick`. Reused by the transmitter.
- Everything else stays in `uart_rx`.

## Test plan
Default parameters unless stated.
- Reset, `rx` held at 1 for 500 cycles -> all outputs 0; `valid_o` never rises.
- Frame 0xA5, even parity bit 0, stop 1, `ready_i` = 1 -> `data_o` = 0xA5 and `valid_o` high for exactly 1 cycle, 171 cycles after the start edge; both error flags 0.
- Frame 0x3C with parity bit 1, then frame 0x00 with stop bit 0 -> first frame: `parity_err_o` = 1, `data_o` = 0x3C. Second frame: `frame_err_o` = 1. FSM stays in BREAK until `rx` returns high; no further frame is produced.
- 4-cycle low glitch on idle `rx` -> false start; no `valid_o`; the next legal frame 0x55 is received correctly.
- `ready_i` = 0, frames 0x11 then 0x22 -> `data_o` stays 0x11, `overrun_o` pulses once. Then `ready_i` = 1 exactly in the completion cycle of frame 0x33 -> 0x11 is accepted, 0x33 loads, no overrun.
- Assert `rst` during data bit 4 of frame 0xF0, deassert, then send 0x0F -> only 0x0F appears, with no error flags.
